// File: rtl/alu_sum_4b_pkg.sv
// Shared constants for the PC-increment adder: default width, step and slice size.
// Latency: n/a (constants and helpers only).
// Backpressure: n/a.
package alu_sum_4b_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_INC   = 4;
    localparam int SLICE_W   = 4;

    // Number of ripple slices needed to cover a given operand width.
    function automatic int num_slices(input int width);
        return width / SLICE_W;
    endfunction

endpackage

// File: rtl/alu_sum_4b_if.sv
// Operand/result bundle between the PC-increment adder and its user.
// Latency: n/a (wiring only).
// Backpressure: none; en is a plain load strobe.
interface alu_sum_4b_if #(
    parameter int WIDTH = 32
);
    logic             en;
    logic [WIDTH-1:0] src;
    logic [WIDTH-1:0] res_comb;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic             valid;

    modport master (
        output en,
        output src,
        input  res_comb,
        input  res,
        input  carry,
        input  valid
    );

    modport slave (
        input  en,
        input  src,
        output res_comb,
        output res,
        output carry,
        output valid
    );
endinterface

// File: rtl/alu_sum_4b_adder_4b.sv
// Four-bit full adder slice used as one link of the ripple chain.
// Latency: combinational. Backpressure: n/a.
module adder_4b (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [4:0] sum_w;

    assign sum_w = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    assign s     = sum_w[3:0];
    assign cout  = sum_w[4];

endmodule

// File: rtl/alu_sum_4b.sv
// Constant-step incrementer (src + INC) with combinational and registered results.
// Latency: res_comb 0 cycles; res/carry/valid 1 cycle after an edge with en high.
// Backpressure: none; registers hold while en is low.
module alu_sum_4b
    import alu_sum_4b_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int INC   = DEF_INC
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_sum_4b_if.slave  bus
);

    localparam int NS = num_slices(WIDTH);
    localparam logic [SLICE_W-1:0] INC_NIB = SLICE_W'(INC);

    generate
        if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_bad_width
            $error("alu_sum_4b: WIDTH must be a positive multiple of 4");
        end
        if (INC < 0 || INC >= 16) begin : g_bad_inc
            $error("alu_sum_4b: INC must be in 0..15");
        end
    endgenerate

    logic [NS:0]      chain_c;
    logic [WIDTH-1:0] sum_w;

    assign chain_c[0] = 1'b0;

    // Only slice 0 sees the step; upper slices just absorb the ripple carry.
    genvar gi;
    generate
        for (gi = 0; gi < NS; gi++) begin : g_slice
            logic [SLICE_W-1:0] addend_w;
            if (gi == 0) begin : g_lsb
                assign addend_w = INC_NIB;
            end else begin : g_upper
                assign addend_w = '0;
            end

            adder_4b u_adder (
                .a    (bus.src[gi*SLICE_W +: SLICE_W]),
                .b    (addend_w),
                .cin  (chain_c[gi]),
                .s    (sum_w[gi*SLICE_W +: SLICE_W]),
                .cout (chain_c[gi+1])
            );
        end
    endgenerate

    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic             valid_q, valid_d;

    always_comb begin
        res_d   = res_q;
        carry_d = carry_q;
        valid_d = bus.en;
        if (bus.en) begin
            res_d   = sum_w;
            carry_d = chain_c[NS];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q   <= '0;
            carry_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            res_q   <= res_d;
            carry_q <= carry_d;
            valid_q <= valid_d;
        end
    end

    assign bus.res_comb = sum_w;
    assign bus.res      = res_q;
    assign bus.carry    = carry_q;
    assign bus.valid    = valid_q;

endmodule

// File: tb/tb_alu_sum_4b.sv
// Self-checking bench for alu_sum_4b: directed vector table, async-reset sequence,
// and randomized traffic against a plain-arithmetic reference model.
module tb_alu_sum_4b;

    localparam int WIDTH = 32;
    localparam int INC   = 4;
    localparam longint unsigned MODV = 64'd1 << WIDTH;

    logic clk;
    logic rst_n;

    alu_sum_4b_if #(.WIDTH(WIDTH)) bus ();

    alu_sum_4b #(.WIDTH(WIDTH), .INC(INC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: what the registered outputs should hold.
    logic [WIDTH-1:0] m_res;
    logic             m_carry;
    logic             m_valid;

    function automatic logic [WIDTH-1:0] ref_sum(input logic [WIDTH-1:0] s);
        longint unsigned v;
        v = longint'(s);
        return WIDTH'((v + INC) % MODV);
    endfunction

    function automatic logic ref_wrap(input logic [WIDTH-1:0] s);
        longint unsigned v;
        v = longint'(s);
        return (v >= MODV - INC);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_regs(input string tag);
        check({tag, " res"},   64'(bus.res),   64'(m_res));
        check({tag, " carry"}, 64'(bus.carry), 64'(m_carry));
        check({tag, " valid"}, 64'(bus.valid), 64'(m_valid));
    endtask

    // Called at posedge+1: drive, check the combinational sum, clock, check regs.
    task automatic step(input logic en_v, input logic [WIDTH-1:0] src_v, input string tag);
        bus.en  = en_v;
        bus.src = src_v;
        #1;
        check({tag, " res_comb"}, 64'(bus.res_comb), 64'(ref_sum(src_v)));
        @(posedge clk);
        if (en_v) begin
            m_res   = ref_sum(src_v);
            m_carry = ref_wrap(src_v);
        end
        m_valid = en_v;
        #1;
        check_regs(tag);
    endtask

    typedef struct {
        logic             en;
        logic [WIDTH-1:0] src;
        logic [WIDTH-1:0] exp_comb;
        logic [WIDTH-1:0] exp_res;
        logic             exp_carry;
        logic             exp_valid;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{1'b1, 32'h0000_0001, 32'h0000_0005, 32'h0000_0005, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 32'h0000_0010, 32'h0000_0014, 32'h0000_0014, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 32'h0000_0100, 32'h0000_0104, 32'h0000_0014, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1};
        vecs[4] = '{1'b1, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 32'h0000_0005, 32'h0000_0009, 32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 32'h0000_000F, 32'h0000_0013, 32'h0000_0013, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 32'h0FFF_FFFE, 32'h1000_0002, 32'h1000_0002, 1'b0, 1'b1};
        vecs[8] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0003, 32'h0000_0003, 1'b1, 1'b1};
        vecs[9] = '{1'b0, 32'h0000_0000, 32'h0000_0004, 32'h0000_0003, 1'b1, 1'b0};

        rst_n   = 1'b0;
        bus.en  = 1'b0;
        bus.src = '0;
        m_res   = '0;
        m_carry = 1'b0;
        m_valid = 1'b0;

        // Reset state, including an enabled edge while reset is held.
        repeat (2) @(posedge clk);
        #1;
        check_regs("reset");
        check("reset res_comb", 64'(bus.res_comb), 64'h4);
        bus.en  = 1'b1;
        bus.src = 32'h0000_0005;
        @(posedge clk);
        #1;
        check_regs("reset_en");
        bus.en  = 1'b0;
        bus.src = '0;
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors with hand-computed expectations.
        for (int i = 0; i < 10; i++) begin
            bus.en  = vecs[i].en;
            bus.src = vecs[i].src;
            #1;
            check($sformatf("vec%0d res_comb", i), 64'(bus.res_comb), 64'(vecs[i].exp_comb));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d res", i),   64'(bus.res),   64'(vecs[i].exp_res));
            check($sformatf("vec%0d carry", i), 64'(bus.carry), 64'(vecs[i].exp_carry));
            check($sformatf("vec%0d valid", i), 64'(bus.valid), 64'(vecs[i].exp_valid));
            check($sformatf("vec%0d comb_after", i), 64'(bus.res_comb), 64'(vecs[i].exp_comb));
        end
        m_res   = 32'h0000_0003;
        m_carry = 1'b1;
        m_valid = 1'b0;

        // Asynchronous reset mid-cycle during an enabled cycle.
        step(1'b1, 32'hFFFF_FFFE, "pre_rst");
        bus.en  = 1'b1;
        bus.src = 32'h0000_0020;
        #2;
        rst_n = 1'b0;
        #1;
        m_res   = '0;
        m_carry = 1'b0;
        m_valid = 1'b0;
        check_regs("async_rst");
        check("async_rst res_comb", 64'(bus.res_comb), 64'h24);
        @(posedge clk);
        #1;
        check_regs("rst_held");
        rst_n = 1'b1;
        step(1'b1, 32'h0000_0040, "post_rst");
        step(1'b0, 32'h0000_0080, "post_rst_hold");

        // Randomized traffic, biased toward the wrap boundary.
        for (int i = 0; i < 300; i++) begin
            logic [WIDTH-1:0] s;
            case ($urandom_range(0, 3))
                0:       s = 32'hFFFF_FFFF - 32'($urandom_range(0, 8));
                1:       s = 32'($urandom_range(0, 20));
                default: s = 32'($urandom);
            endcase
            step(1'($urandom_range(0, 1)), s, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_sum_4b.md
ALU_SUM_4B -- requirements
Module: alu_sum_4b

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; SHALL be a multiple of 4.
REQ-002 Parameter INC, default 4, constant addend (PC-increment step, one RISC-V instruction); SHALL be less than 16.
REQ-003 clk  input  1  single clock; all registers update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  load strobe; when high, the registered outputs capture the new sum.
REQ-006 src  input  WIDTH  operand (typically the current PC).
REQ-007 res_comb  output  WIDTH  combinational src + INC.
REQ-008 res  output  WIDTH  registered src + INC.
REQ-009 carry  output  1  registered carry-out of the addition, i.e. wrap-around flag.
REQ-010 valid  output  1  registered flag; high for exactly one cycle after each cycle with en high.

Function
REQ-011 res_comb SHALL equal (src + INC) mod 2^WIDTH with zero clock latency.
REQ-012 On a rising clk edge with en=1, res SHALL load res_comb and carry SHALL load bit WIDTH of src + INC; latency is 1 cycle.
REQ-013 On a rising clk edge with en=0, res and carry SHALL hold their values.
REQ-014 valid SHALL register en each cycle, so valid=1 exactly in the cycle following a cycle with en=1.
REQ-015 Wrap-around: if src >= 2^WIDTH - INC, then res SHALL equal src + INC - 2^WIDTH and carry SHALL be 1; otherwise carry SHALL be 0.
REQ-016 Any src value, including X-free changes between edges, SHALL affect only res_comb until the next enabled edge.
REQ-017 The adder SHALL be a ripple chain of WIDTH/4 four-bit slices.
    - Slice 0 receives INC[3:0] with carry-in 0.
    - Higher slices receive addend 0 plus the carry from the previous slice.
REQ-018 res_comb SHALL be the concatenated slice sums; the final slice carry SHALL be the carry source.
REQ-019 The design SHALL contain no latches; no combinational path SHALL exist from src to res, carry or valid.

Reset
REQ-020 While rst_n=0, res SHALL be 0, carry SHALL be 0 and valid SHALL be 0, independent of clk.
REQ-021 Reset SHALL take effect immediately on rst_n falling, including during an enabled cycle.
REQ-022 Release of rst_n SHALL be synchronized by the integration level; the first enabled edge after release SHALL load normally.
REQ-023 res_comb is unaffected by reset.

Structure
REQ-024 A shared package SHALL hold the default WIDTH (32), INC (4) and slice width (4) constants.
REQ-025 One sub-module, adder_4b, SHALL be used.
    - Inputs: a[3:0], b[3:0], cin.
    - Outputs: s[3:0], cout.
    - Instantiated WIDTH/4 times via generate.

Verification
REQ-026 Reset asserted, src=0x00000000 -> res=0, carry=0, valid=0, res_comb=0x00000004.
REQ-027 src=0x00000001, en=1, one edge -> res=0x00000005, carry=0, valid=1 in the next cycle.
REQ-028 src=0x00000010, en=1 -> res=0x00000014; then src changed to 0x00000100 with en=0 -> res holds 0x00000014, res_comb=0x00000104, valid=0.
REQ-029 src=0xFFFFFFFC, en=1 -> res=0x00000000, carry=1; src=0xFFFFFFFB -> res=0xFFFFFFFF, carry=0.
REQ-030 src=0x0000000F (slice-carry ripple) -> res=0x00000013; src=0x0FFFFFFE -> res=0x10000002.
REQ-031 rst_n pulsed low mid-cycle with en=1 -> res, carry, valid drop to 0 before the next edge, then resume loading after release.
